// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, access sizes,
// and the alignment check used when a request is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] SZ_B      = 3'b000;
    localparam logic [2:0] SZ_H      = 3'b001;
    localparam logic [2:0] SZ_W      = 3'b010;
    localparam logic [2:0] SZ_BU     = 3'b100;
    localparam logic [2:0] SZ_HU     = 3'b101;
    localparam logic [2:0] SIZE_IDLE = 3'b111;

    // Unsupported encodings fold into the misaligned path so they never reach memory.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            SZ_B, SZ_BU: misaligned = 1'b0;
            SZ_H, SZ_HU: misaligned = lane[0];
            SZ_W:        misaligned = (lane != 2'b00);
            default:     misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane extraction for loads: pick the byte/half addressed by
// lane out of the memory word and sign- or zero-extend it to DATA_WIDTH.
module load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            lane,
    input  logic [2:0]            size,
    output logic [DATA_WIDTH-1:0] result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = 8'(word >> {lane, 3'b000});
        lane_half = 16'(word >> {lane[1], 4'b0000});
        case (size)
            SZ_B:    result = {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
            SZ_BU:   result = {{(DATA_WIDTH-8){1'b0}}, lane_byte};
            SZ_H:    result = {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
            SZ_HU:   result = {{(DATA_WIDTH-16){1'b0}}, lane_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the pipeline to a memory controller.
// Optional watchdog on the memory handshake is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 17,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  MemWrite,
    output logic [2:0]            SizeCtr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] WriteData,
    input  logic [DATA_WIDTH-1:0] ReadData,
    input  logic                  MemReady,
    output logic                  busy
);

    lsu_state_t            state;
    logic                  hold_write;
    logic [2:0]            hold_size;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] ext_data;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic                  bad_req;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
`endif

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .word   (ReadData),
        .lane   (hold_addr[1:0]),
        .size   (hold_size),
        .result (ext_data)
    );

    assign bad_req = misaligned(req_size, req_addr[1:0]);

    // Stores are lane-placed at capture so WAIT simply replays the held word.
    always_comb begin
        lane_wdata = '0;
        case (req_size)
            SZ_B, SZ_BU: lane_wdata = DATA_WIDTH'(req_wdata[7:0]) << {req_addr[1:0], 3'b000};
            SZ_H, SZ_HU: lane_wdata = DATA_WIDTH'(req_wdata[15:0]) << {req_addr[1], 4'b0000};
            SZ_W:        lane_wdata = req_wdata;
            default:     lane_wdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_write <= 1'b0;
            hold_size  <= SIZE_IDLE;
            hold_addr  <= '0;
            hold_wdata <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        hold_write <= req_write;
                        hold_size  <= req_size;
                        hold_addr  <= req_addr;
                        hold_wdata <= lane_wdata;
                        rdata_q    <= '0;
                        err_q      <= bad_req;
                        state      <= bad_req ? ST_RESP : ST_WAIT;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (MemReady) begin
                        rdata_q <= hold_write ? '0 : ext_data;
                        err_q   <= 1'b0;
                        state   <= ST_RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory-side outputs are only live in WAIT; everywhere else they rest at idle values.
    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;
    assign MemWrite   = (state == ST_WAIT) & hold_write;
    assign SizeCtr    = (state == ST_WAIT) ? hold_size : SIZE_IDLE;
    assign addr       = (state == ST_WAIT) ? hold_addr : '0;
    assign WriteData  = (state == ST_WAIT && hold_write) ? hold_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs change and outputs are sampled on
// the falling edge; expected values are hand-computed constants.
module tb_load_store_unit;

    localparam int DW = 32;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_write;
    logic [2:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready, resp_valid, resp_err;
    logic [DW-1:0] resp_rdata;
    logic          MemWrite;
    logic [2:0]    SizeCtr;
    logic [AW-1:0] addr;
    logic [DW-1:0] WriteData, ReadData;
    logic          MemReady, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemWrite(MemWrite), .SizeCtr(SizeCtr), .addr(addr), .WriteData(WriteData),
        .ReadData(ReadData), .MemReady(MemReady), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns on the next falling edge.
    task automatic issue(input logic w, input logic [2:0] sz, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_size = 3'b000; req_addr = '0; req_wdata = '0;
    endtask

    task automatic mem_done(input logic [DW-1:0] rd);
        MemReady = 1'b1; ReadData = rd;
        @(negedge clk);
        MemReady = 1'b0; ReadData = '0;
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] rd, input logic err);
        chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
        chk({tag, ".rdata"}, resp_rdata, rd);
        chk({tag, ".err"},   32'(resp_err), 32'(err));
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 3'b000;
        req_addr = '0; req_wdata = '0; ReadData = '0; MemReady = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst.ready",   32'(req_ready), 32'd1);
        chk("rst.busy",    32'(busy), 32'd0);
        chk("rst.size",    32'(SizeCtr), 32'h7);
        chk("rst.mw",      32'(MemWrite), 32'd0);
        chk("rst.addr",    32'(addr), 32'd0);
        chk("rst.wd",      WriteData, 32'd0);
        chk("rst.valid",   32'(resp_valid), 32'd0);
        rst_n = 1'b1;

        // MemReady while idle must have no effect
        MemReady = 1'b1; ReadData = 32'h1234_5678;
        @(negedge clk);
        chk("idle.valid", 32'(resp_valid), 32'd0);
        chk("idle.size",  32'(SizeCtr), 32'h7);
        MemReady = 1'b0; ReadData = '0;

        // lw 0x10, three WAIT cycles before MemReady
        issue(1'b0, 3'b010, 17'h00010, '0);
        for (int i = 0; i < 3; i++) begin
            chk("lw.size", 32'(SizeCtr), 32'h2);
            chk("lw.addr", 32'(addr), 32'h10);
            chk("lw.busy", 32'(busy), 32'd1);
            chk("lw.nvld", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        mem_done(32'hDEAD_BEEF);
        chk_resp("lw", 32'hDEAD_BEEF, 1'b0);

        // lb / lbu from lane 3
        issue(1'b0, 3'b000, 17'h00013, '0);
        mem_done(32'h80FF_FFFF);
        chk_resp("lb", 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 3'b100, 17'h00013, '0);
        mem_done(32'h80FF_FFFF);
        chk_resp("lbu", 32'h0000_0080, 1'b0);

        // lh / lhu from upper half, lb from lane 0 positive
        issue(1'b0, 3'b001, 17'h00002, '0);
        mem_done(32'h8001_1234);
        chk_resp("lh", 32'hFFFF_8001, 1'b0);
        issue(1'b0, 3'b101, 17'h00002, '0);
        mem_done(32'h8001_1234);
        chk_resp("lhu", 32'h0000_8001, 1'b0);
        issue(1'b0, 3'b000, 17'h00004, '0);
        mem_done(32'hFFFF_FF7F);
        chk_resp("lb0", 32'h0000_007F, 1'b0);

        // sh 0x2 held for two cycles before MemReady
        issue(1'b1, 3'b001, 17'h00002, 32'h0000_ABCD);
        for (int i = 0; i < 2; i++) begin
            chk("sh.wd",   WriteData, 32'hABCD_0000);
            chk("sh.size", 32'(SizeCtr), 32'h1);
            chk("sh.mw",   32'(MemWrite), 32'd1);
            chk("sh.addr", 32'(addr), 32'h2);
            @(negedge clk);
        end
        mem_done(32'hFFFF_FFFF);
        chk_resp("sh", 32'd0, 1'b0);
        chk("sh.mw_off", 32'(MemWrite), 32'd0);

        // sb lane 1 and sw
        issue(1'b1, 3'b000, 17'h00101, 32'h1234_56EF);
        chk("sb.wd",   WriteData, 32'h0000_EF00);
        chk("sb.size", 32'(SizeCtr), 32'h0);
        mem_done('0);
        chk_resp("sb", 32'd0, 1'b0);
        issue(1'b1, 3'b010, 17'h00104, 32'hCAFE_F00D);
        chk("sw.wd", WriteData, 32'hCAFE_F00D);
        mem_done('0);
        chk_resp("sw", 32'd0, 1'b0);

        // misaligned / unsupported go straight to an error response
        issue(1'b0, 3'b010, 17'h00001, '0);
        chk("mis_lw.size", 32'(SizeCtr), 32'h7);
        chk_resp("mis_lw", 32'd0, 1'b1);
        issue(1'b0, 3'b101, 17'h00003, '0);
        chk("mis_lhu.size", 32'(SizeCtr), 32'h7);
        chk_resp("mis_lhu", 32'd0, 1'b1);
        issue(1'b1, 3'b011, 17'h00000, 32'hFFFF_FFFF);
        chk("bad_sz.mw", 32'(MemWrite), 32'd0);
        chk_resp("bad_sz", 32'd0, 1'b1);

        // reset during WAIT abandons the access
        issue(1'b0, 3'b010, 17'h00020, '0);
        chk("rstw.size", 32'(SizeCtr), 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw.ready", 32'(req_ready), 32'd1);
        chk("rstw.size2", 32'(SizeCtr), 32'h7);
        chk("rstw.valid", 32'(resp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw.valid2", 32'(resp_valid), 32'd0);
        chk("rstw.busy",   32'(busy), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // watchdog: eight WAIT cycles without MemReady, then error response
        issue(1'b0, 3'b010, 17'h00008, '0);
        repeat (7) @(negedge clk);
        chk("to.still_wait", 32'(SizeCtr), 32'h2);
        chk("to.nvld",       32'(resp_valid), 32'd0);
        @(negedge clk);
        chk_resp("to", 32'd0, 1'b1);
`else
        // without the watchdog WAIT holds until MemReady
        issue(1'b0, 3'b010, 17'h00008, '0);
        repeat (12) @(negedge clk);
        chk("hold.size", 32'(SizeCtr), 32'h2);
        chk("hold.nvld", 32'(resp_valid), 32'd0);
        mem_done(32'h0BAD_F00D);
        chk_resp("hold", 32'h0BAD_F00D, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
